// File: rtl/gyro_down_timer_if.sv
// gyro_down_timer_if
//   Groups the control and status signals of gyro_down_timer so the timer
//   can be wired to the register bank as a single port.
//
//   Parameters
//     WIDTH       counter / reload width
//     PRESCALE_W  prescaler width
//
//   Signals
//     load, load_value, en, auto_reload, prescale : controller -> timer
//     count, busy, tick, tc_pulse                 : timer -> controller
//
//   Modports
//     master : the controller side (register bank or testbench)
//     slave  : the timer itself
interface gyro_down_timer_if #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
);
    logic                  load;
    logic [WIDTH-1:0]      load_value;
    logic                  en;
    logic                  auto_reload;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  tick;
    logic                  tc_pulse;

    modport master (
        output load, load_value, en, auto_reload, prescale,
        input  count, busy, tick, tc_pulse
    );

    modport slave (
        input  load, load_value, en, auto_reload, prescale,
        output count, busy, tick, tc_pulse
    );
endinterface

// File: rtl/gyro_down_timer.sv
// gyro_down_timer
//   Programmable down-timer with synchronous load, clock-enable prescaler,
//   one-shot / auto-reload modes and a registered terminal-count pulse.
//   Everything runs on the single clock; no derived clocks are produced.
//
//   Parameters
//     WIDTH       counter and reload width (2..32)
//     PRESCALE_W  prescaler width; divide ratio is prescale+1
//
//   Ports
//     clock    sole clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      gyro_down_timer_if.slave:
//                load/load_value  synchronous load (priority over counting)
//                en               count enable (freezes prescaler + counter)
//                auto_reload      1 = periodic, 0 = one-shot (sampled live)
//                prescale         prescaler terminal value (sampled live)
//                count            registered counter value
//                busy             registered armed/running flag
//                tick             combinational decrement strobe
//                tc_pulse         registered terminal-count pulse
module gyro_down_timer #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    gyro_down_timer_if.slave bus
);

    logic [WIDTH-1:0]      count_reg,  count_next;
    logic [WIDTH-1:0]      reload_reg, reload_next;
    logic [PRESCALE_W-1:0] pcnt_reg,   pcnt_next;
    logic                  busy_reg,   busy_next;
    logic                  tc_reg,     tc_next;
    logic                  tick;

    // ">=" rather than "==" so that lowering prescale below the current
    // prescaler value fires on the next cycle instead of wrapping round.
    assign tick = bus.en & busy_reg & ~bus.load & (pcnt_reg >= bus.prescale);

    always_comb begin
        count_next  = count_reg;
        reload_next = reload_reg;
        pcnt_next   = pcnt_reg;
        busy_next   = busy_reg;
        tc_next     = 1'b0;          // pulse lasts exactly one cycle

        if (bus.load) begin
            // Load wins over everything, including a pending terminal tick.
            count_next  = bus.load_value;
            reload_next = bus.load_value;
            pcnt_next   = '0;
            busy_next   = (bus.load_value != '0);
        end else if (bus.en && busy_reg) begin
            if (tick) begin
                pcnt_next = '0;
                if (count_reg != WIDTH'(1)) begin
                    count_next = count_reg - WIDTH'(1);
                end else if (bus.auto_reload) begin
                    // reload_reg is non-zero here: busy only rises on a
                    // non-zero load, so the period can never collapse to 0.
                    count_next = reload_reg;
                    tc_next    = 1'b1;
                end else begin
                    count_next = '0;
                    busy_next  = 1'b0;
                    tc_next    = 1'b1;
                end
            end else begin
                pcnt_next = pcnt_reg + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg  <= '0;
            reload_reg <= '0;
            pcnt_reg   <= '0;
            busy_reg   <= 1'b0;
            tc_reg     <= 1'b0;
        end else begin
            count_reg  <= count_next;
            reload_reg <= reload_next;
            pcnt_reg   <= pcnt_next;
            busy_reg   <= busy_next;
            tc_reg     <= tc_next;
        end
    end

    assign bus.count    = count_reg;
    assign bus.busy     = busy_reg;
    assign bus.tick     = tick;
    assign bus.tc_pulse = tc_reg;

endmodule

// File: tb/tb_gyro_down_timer.sv
// tb_gyro_down_timer
//   Directed bench for gyro_down_timer. A default-width instance is checked
//   every cycle against a behavioural model; directed sequences also pin
//   hand-computed values. A WIDTH=32 / PRESCALE_W=4 instance covers the
//   wide-counter boundaries.
module tb_gyro_down_timer;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    always #5 clock = ~clock;

    gyro_down_timer_if #(.WIDTH(16), .PRESCALE_W(8)) bus ();
    gyro_down_timer_if #(.WIDTH(32), .PRESCALE_W(4)) bus32 ();

    gyro_down_timer #(.WIDTH(16), .PRESCALE_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    gyro_down_timer #(.WIDTH(32), .PRESCALE_W(4)) dut32 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus32)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change and literals are
    // sampled 1 ns after the edge.
    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: a timer expressed as "enabled cycles elapsed in the
    // current period" against the period length prescale+1.
    // ---------------------------------------------------------------------
    int m_count, m_reload, m_elapsed;
    bit m_busy, m_tc;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_count   <= 0;
            m_reload  <= 0;
            m_elapsed <= 0;
            m_busy    <= 0;
            m_tc      <= 0;
        end else if (bus.load) begin
            m_count   <= int'(bus.load_value);
            m_reload  <= int'(bus.load_value);
            m_elapsed <= 0;
            m_busy    <= (bus.load_value != 0);
            m_tc      <= 0;
        end else begin
            m_tc <= 0;
            if (bus.en && m_busy) begin
                if (m_elapsed + 1 >= int'(bus.prescale) + 1) begin
                    m_elapsed <= 0;
                    if (m_count > 1)           m_count <= m_count - 1;
                    else if (bus.auto_reload) begin
                        m_count <= m_reload;
                        m_tc    <= 1;
                    end else begin
                        m_count <= 0;
                        m_busy  <= 0;
                        m_tc    <= 1;
                    end
                end else begin
                    m_elapsed <= m_elapsed + 1;
                end
            end
        end
    end

    // Cycle-by-cycle compare on the falling edge.
    always @(negedge clock) begin
        automatic bit exp_tick = bus.en && m_busy && !bus.load &&
                                 (m_elapsed >= int'(bus.prescale));
        chk("model_count", 32'(bus.count), 32'(m_count));
        chk("model_busy",  32'(bus.busy), 32'(m_busy));
        chk("model_tc",    32'(bus.tc_pulse), 32'(m_tc));
        chk("model_tick",  32'(bus.tick), 32'(exp_tick));
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        bus.load = 0; bus.load_value = 0; bus.en = 0; bus.auto_reload = 0; bus.prescale = 0;
        bus32.load = 0; bus32.load_value = 0; bus32.en = 0; bus32.auto_reload = 0; bus32.prescale = 0;

        // Reset state
        #12;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_tc",    32'(bus.tc_pulse), 0);
        #11 reset_n = 1;                       // released away from an edge

        // Idle: enabled but never loaded
        bus.en = 1;
        for (int i = 0; i < 5; i++) begin
            next_edge();
            chk("idle_count", 32'(bus.count), 0);
            chk("idle_tc",    32'(bus.tc_pulse), 0);
        end

        // One-shot L=5 P=0
        bus.auto_reload = 0; bus.prescale = 0;
        bus.load = 1; bus.load_value = 5;
        next_edge();
        bus.load = 0;
        chk("os_load_count", 32'(bus.count), 5);
        chk("os_load_busy",  32'(bus.busy), 1);
        for (int k = 1; k <= 5; k++) begin
            next_edge();
            chk("os_count", 32'(bus.count), 32'(5 - k));
            chk("os_tc",    32'(bus.tc_pulse), 32'(k == 5));
            chk("os_busy",  32'(bus.busy), 32'(k < 5));
        end
        next_edge();
        chk("os_tc_clear", 32'(bus.tc_pulse), 0);
        chk("os_hold0",    32'(bus.count), 0);

        // Auto-reload L=3 P=2: period 9, five periods
        bus.auto_reload = 1; bus.prescale = 2;
        bus.load = 1; bus.load_value = 3;
        next_edge();
        bus.load = 0;
        pulses = 0;
        for (int k = 1; k <= 45; k++) begin
            next_edge();
            chk("ar_count", 32'(bus.count), 32'(3 - ((k / 3) % 3)));
            chk("ar_tc",    32'(bus.tc_pulse), 32'(k % 9 == 0));
            if (bus.tc_pulse) pulses++;
        end
        chk("ar_pulses", 32'(pulses), 5);

        // Auto-reload L=1 P=0: tc_pulse held high
        bus.prescale = 0;
        bus.load = 1; bus.load_value = 1;
        next_edge();
        bus.load = 0;
        for (int k = 1; k <= 6; k++) begin
            next_edge();
            chk("ar1_tc",    32'(bus.tc_pulse), 1);
            chk("ar1_count", 32'(bus.count), 1);
        end

        // Enable gating L=4 P=1, en low for 7 edges after first decrement
        bus.auto_reload = 0; bus.prescale = 1;
        bus.load = 1; bus.load_value = 4;
        next_edge();
        bus.load = 0;
        for (int k = 1; k <= 16; k++) begin
            next_edge();
            chk("en_tc", 32'(bus.tc_pulse), 32'(k == 15));
            if (k == 2) begin
                chk("en_first_dec", 32'(bus.count), 3);
                bus.en = 0;
            end
            if (k == 9) begin
                chk("en_frozen", 32'(bus.count), 3);
                bus.en = 1;
            end
        end
        chk("en_end_count", 32'(bus.count), 0);
        chk("en_end_busy",  32'(bus.busy), 0);

        // Live prescale lowered mid-run: L=5 P=7, drop to 1 after 3 edges
        bus.prescale = 7;
        bus.load = 1; bus.load_value = 5;
        next_edge();
        bus.load = 0;
        repeat (3) next_edge();
        bus.prescale = 1;
        #1;
        chk("ps_tick_now", 32'(bus.tick), 1);
        next_edge();
        chk("ps_count4", 32'(bus.count), 4);
        repeat (2) next_edge();
        chk("ps_count3", 32'(bus.count), 3);

        // Load priority on the terminal edge of an L=2 P=0 timer
        bus.prescale = 0;
        bus.load = 1; bus.load_value = 2;
        next_edge();
        bus.load = 0;
        next_edge();
        chk("lp_count1", 32'(bus.count), 1);
        bus.load = 1; bus.load_value = 10;
        next_edge();
        bus.load = 0;
        chk("lp_tc",    32'(bus.tc_pulse), 0);
        chk("lp_count", 32'(bus.count), 10);
        chk("lp_busy",  32'(bus.busy), 1);
        next_edge();
        chk("lp_next", 32'(bus.count), 9);

        // load_value = 0 leaves the timer idle
        bus.load = 1; bus.load_value = 0;
        next_edge();
        bus.load = 0;
        chk("z_busy", 32'(bus.busy), 0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            next_edge();
            if (bus.tc_pulse) pulses++;
        end
        chk("z_pulses", 32'(pulses), 0);
        chk("z_count",  32'(bus.count), 0);

        // Asynchronous reset mid-count, then fresh start
        bus.prescale = 3;
        bus.load = 1; bus.load_value = 100;
        next_edge();
        bus.load = 0;
        repeat (10) next_edge();
        #2 reset_n = 0;
        #1;
        chk("ar_rst_count", 32'(bus.count), 0);
        chk("ar_rst_busy",  32'(bus.busy), 0);
        chk("ar_rst_tc",    32'(bus.tc_pulse), 0);
        next_edge();
        #2 reset_n = 1;
        bus.prescale = 0;
        bus.load = 1; bus.load_value = 2;
        next_edge();
        bus.load = 0;
        next_edge();
        chk("fresh_count1", 32'(bus.count), 1);
        next_edge();
        chk("fresh_tc", 32'(bus.tc_pulse), 1);
        chk("fresh_count0", 32'(bus.count), 0);

        // Wide instance: L=0xFFFF_FFFF, P=15 (prescaler at its maximum)
        bus32.en = 1; bus32.auto_reload = 0; bus32.prescale = 15;
        bus32.load = 1; bus32.load_value = 32'hFFFF_FFFF;
        next_edge();
        bus32.load = 0;
        chk("w_load", bus32.count, 32'hFFFF_FFFF);
        chk("w_busy", 32'(bus32.busy), 1);
        repeat (15) next_edge();
        chk("w_hold15", bus32.count, 32'hFFFF_FFFF);
        next_edge();
        chk("w_first_dec", bus32.count, 32'hFFFF_FFFE);
        chk("w_tc", 32'(bus32.tc_pulse), 0);

        // Wide instance: expiry from 1 stays at 0, no wrap
        bus32.prescale = 0;
        bus32.load = 1; bus32.load_value = 1;
        next_edge();
        bus32.load = 0;
        next_edge();
        chk("w_exp_count", bus32.count, 0);
        chk("w_exp_tc", 32'(bus32.tc_pulse), 1);
        repeat (3) next_edge();
        chk("w_nowrap", bus32.count, 0);
        chk("w_idle", 32'(bus32.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
